// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Fetch and load/store streams share one downstream request port.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive data grants made while a fetch waits.
// Saturates at MAX; the arbiter forces a fetch once sat is high.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_CNT_W-1:0] cnt;

  assign sat = (cnt == STARVE_CNT_W'(MAX));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between instruction fetch and load/store.
// Holds the last fetched instruction and load data, and drives the CPU stall.
//
// state | meaning
// IDLE  | no access outstanding, arbitrate this cycle
// FETCH | fetch request on the port, waiting for p_ready
// DATA  | load/store request on the port, waiting for p_ready
// RESP  | one-cycle done pulse to the winning requester
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall,
  output logic              p_req_valid,
  output logic              p_req_rw,
  output logic [ADDR_W-1:0] p_req_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_ready,
  output logic              grant_data
);

  arb_state_e        state, state_nxt;
  logic              grant_d, grant_f;
  logic              starve_sat;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [DATA_W-1:0] req_wdata;
  logic              req_is_data;

  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (grant_d && if_req_valid),
    .clr   (grant_f),
    .sat   (starve_sat)
  );

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_valid && (!if_req_valid || !starve_sat)) begin
          grant_d   = 1'b1;
          state_nxt = DATA;
        end else if (if_req_valid) begin
          grant_f   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH, DATA: begin
        if (p_ready) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      req_addr    <= '0;
      req_rw      <= 1'b0;
      req_wdata   <= '0;
      req_is_data <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        req_addr    <= d_req_addr;
        req_rw      <= d_req_rw;
        req_wdata   <= d_wdata;
        req_is_data <= 1'b1;
      end else if (grant_f) begin
        req_addr    <= if_req_addr;
        req_rw      <= 1'b0;
        req_wdata   <= '0;
        req_is_data <= 1'b0;
      end
      if (state == FETCH && p_ready) if_rdata <= p_rdata;
      // Stores leave the held load data untouched.
      if (state == DATA && p_ready && !req_rw) d_rdata <= p_rdata;
    end
  end

  assign p_req_valid = (state == FETCH) || (state == DATA);
  assign grant_data  = (state == DATA);
  assign p_req_rw    = req_rw;
  assign p_req_addr  = req_addr;
  assign p_wdata     = req_wdata;
  assign if_done     = (state == RESP) && !req_is_data;
  assign d_done      = (state == RESP) && req_is_data;
  assign stall       = (if_req_valid && !if_done) || (d_req_valid && !d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        CLK, RESET;
  logic        if_req_valid, if_done, d_req_valid, d_req_rw, d_done, stall;
  logic [31:0] if_req_addr, if_rdata, d_req_addr, d_wdata, d_rdata;
  logic        p_req_valid, p_req_rw, p_ready, grant_data;
  logic [31:0] p_req_addr, p_wdata, p_rdata;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw), .d_req_addr(d_req_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
    .p_req_valid(p_req_valid), .p_req_rw(p_req_rw), .p_req_addr(p_req_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ready(p_ready), .grant_data(grant_data)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, a done cycle, then idle.
  bit          m_busy, m_resp, m_is_data, m_rw;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int          m_starve;

  initial begin
    m_busy = 0; m_resp = 0; m_is_data = 0; m_rw = 0;
    m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0; m_starve = 0;
  end

  always @(posedge CLK) begin
    if (RESET) begin
      m_busy = 0; m_resp = 0; m_is_data = 0; m_rw = 0;
      m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0; m_starve = 0;
    end else if (m_resp) begin
      m_resp = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (p_ready) begin
        if (!m_is_data) m_if_rdata = p_rdata;
        else if (!m_rw) m_d_rdata = p_rdata;
        m_resp = 1;
      end
    end else if (d_req_valid && (!if_req_valid || m_starve < SMAX)) begin
      m_busy = 1; m_is_data = 1;
      m_addr = d_req_addr; m_rw = d_req_rw; m_wdata = d_wdata;
      if (if_req_valid) m_starve = m_starve + 1;
    end else if (if_req_valid) begin
      m_busy = 1; m_is_data = 0;
      m_addr = if_req_addr; m_rw = 0; m_wdata = 0;
      m_starve = 0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("p_req_valid", p_req_valid, m_busy && !m_resp);
      check("grant_data",  grant_data,  m_busy && !m_resp && m_is_data);
      check("if_done",     if_done,     m_resp && !m_is_data);
      check("d_done",      d_done,      m_resp && m_is_data);
      check("p_req_addr",  p_req_addr,  m_addr);
      check("p_req_rw",    p_req_rw,    m_rw);
      check("p_wdata",     p_wdata,     m_wdata);
      check("if_rdata",    if_rdata,    m_if_rdata);
      check("d_rdata",     d_rdata,     m_d_rdata);
      check("stall", stall, (if_req_valid && !(m_resp && !m_is_data)) ||
                            (d_req_valid && !(m_resp && m_is_data)));
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  int  ndata, npulse;
  bit  got_fetch, prev_v;
  bit  rst_pulse;

  initial begin
    RESET = 1; if_req_valid = 0; if_req_addr = 0; d_req_valid = 0; d_req_rw = 0;
    d_req_addr = 0; d_wdata = 0; p_rdata = 0; p_ready = 0;
    repeat (3) step();
    RESET = 0;
    chk_en = 1;
    check("rst p_req_valid", p_req_valid, 0);
    check("rst if_rdata", if_rdata, 0);
    check("rst d_rdata", d_rdata, 0);
    check("rst done", {if_done, d_done, grant_data, stall}, 0);

    // Lone fetch with zero-wait memory
    if_req_valid = 1; if_req_addr = 32'h8; p_ready = 1; p_rdata = 32'hE59F120C;
    step();
    check("fetch valid t+1", p_req_valid, 1);
    check("fetch addr t+1", p_req_addr, 32'h8);
    check("fetch rw t+1", p_req_rw, 0);
    step();
    check("fetch if_done t+2", if_done, 1);
    check("fetch stall in done", stall, 0);
    if_req_valid = 0; p_ready = 0; p_rdata = 32'h0;
    step();
    check("fetch if_done once", if_done, 0);
    check("fetch if_rdata held", if_rdata, 32'hE59F120C);

    // Simultaneous fetch and read: data wins while starve count is 0
    step();
    if_req_valid = 1; if_req_addr = 32'h0;
    d_req_valid = 1; d_req_rw = 0; d_req_addr = 32'h200; p_ready = 1; p_rdata = 32'h12345678;
    step();
    check("sim grant_data", grant_data, 1);
    check("sim data addr", p_req_addr, 32'h200);
    step();
    check("sim d_done", d_done, 1);
    check("sim d_rdata", d_rdata, 32'h12345678);
    d_req_valid = 0; p_rdata = 32'hCAFEF00D;
    step();
    step();
    check("sim fetch grant", {p_req_valid, grant_data}, 2'b10);
    check("sim fetch addr", p_req_addr, 32'h0);
    step();
    check("sim if_done", if_done, 1);
    check("sim if_rdata", if_rdata, 32'hCAFEF00D);
    if_req_valid = 0; p_ready = 0;
    step();

    // Starvation bound: data held with fetch pending
    if_req_valid = 1; if_req_addr = 32'h40;
    d_req_valid = 1; d_req_rw = 0; d_req_addr = 32'h100; p_ready = 1; p_rdata = 32'h11112222;
    ndata = 0; got_fetch = 0; prev_v = 0;
    for (int i = 0; i < 60 && !got_fetch; i++) begin
      step();
      if (p_req_valid && !prev_v) begin
        if (grant_data) ndata++;
        else got_fetch = 1;
      end
      prev_v = p_req_valid;
    end
    check("starve fetch reached", got_fetch, 1);
    check("starve data grants", ndata, SMAX);
    step();
    check("starve if_done", if_done, 1);
    if_req_valid = 0; d_req_valid = 0; p_ready = 0;
    step();
    step();

    // Delayed write: port outputs stable while waiting; late requester changes ignored
    d_req_valid = 1; d_req_rw = 1; d_req_addr = 32'h800; d_wdata = 32'h5;
    step();
    d_req_addr = 32'h999; d_wdata = 32'h7;
    for (int i = 0; i < 3; i++) begin
      check("wr stable valid", p_req_valid, 1);
      check("wr stable rw", p_req_rw, 1);
      check("wr stable addr", p_req_addr, 32'h800);
      check("wr stable wdata", p_wdata, 32'h5);
      check("wr no done", d_done, 0);
      if (i == 2) p_ready = 1;
      step();
    end
    check("wr d_done", d_done, 1);
    check("wr d_rdata unchanged", d_rdata, 32'h11112222);
    d_req_valid = 0; p_ready = 0; d_req_rw = 0;
    step();
    check("wr d_done once", d_done, 0);

    // Reset during a data wait
    d_req_valid = 1; d_req_addr = 32'h300;
    step();
    check("rstmid granted", grant_data, 1);
    RESET = 1;
    step();
    check("rstmid p_req_valid", p_req_valid, 0);
    check("rstmid outputs", {d_done, if_done, grant_data, p_req_rw}, 0);
    check("rstmid addr", p_req_addr, 0);
    check("rstmid rdata", if_rdata | d_rdata, 0);
    RESET = 0; d_req_valid = 0;
    step();
    check("rstmid no d_done", d_done, 0);
    if_req_valid = 1; if_req_addr = 32'h10; p_ready = 1; p_rdata = 32'h0F0F0F0F;
    step();
    check("post-rst fetch addr", p_req_addr, 32'h10);
    step();
    check("post-rst if_done", if_done, 1);
    check("post-rst if_rdata", if_rdata, 32'h0F0F0F0F);
    if_req_valid = 0; p_ready = 0;
    step();

    // Data requester drops valid after grant
    d_req_valid = 1; d_req_addr = 32'h44;
    step();
    check("drop granted", grant_data, 1);
    d_req_valid = 0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) p_ready = 1;
      step();
      if (d_done) npulse++;
    end
    check("drop d_done pulses", npulse, 1);
    p_ready = 0;

    // Randomized traffic against the model
    rst_pulse = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst_pulse) begin
        RESET = 0; rst_pulse = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        RESET = 1; rst_pulse = 1;
      end
      if (!if_req_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          if_req_valid = 1; if_req_addr = $urandom & 32'h0000FFFC;
        end
      end else if (m_resp && !m_is_data) begin
        if ($urandom_range(0, 1) == 1) if_req_addr = $urandom & 32'h0000FFFC;
        else if_req_valid = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        if_req_valid = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        if_req_addr = $urandom;
      end
      if (!d_req_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req_valid = 1; d_req_rw = $urandom_range(0, 1) == 1;
          d_req_addr = $urandom; d_wdata = $urandom;
        end
      end else if (m_resp && m_is_data) begin
        if ($urandom_range(0, 3) != 0) begin
          d_req_rw = $urandom_range(0, 1) == 1; d_req_addr = $urandom; d_wdata = $urandom;
        end else d_req_valid = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        d_req_valid = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        d_req_addr = $urandom; d_wdata = $urandom;
      end
      p_ready = $urandom_range(0, 2) != 0;
      p_rdata = $urandom;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single cache/memory request port between the CPU's instruction-fetch stream and its load/store stream. It replaces the ad-hoc latching of fetched instructions and read data with registered, held response buffers. It also generates the CPU stall signal. It sits between the ARM core and associative_cache: requesters on one side, one valid/ready port on the other.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while a fetch is pending before fetch is forced (1..15)

Ports:
- CLK  in  1  clock; everything is rising-edge
- RESET  in  1  synchronous reset, active-high
- if_req_valid  in  1  instruction fetch request; held until if_done
- if_req_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  last fetched instruction, held between fetches
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- d_req_valid  in  1  data request; held until d_done
- d_req_rw  in  1  1 = write, 0 = read
- d_req_addr  in  ADDR_W  data address (ALUResult)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  last load data, held between loads
- d_done  out  1  one-cycle pulse: data access complete
- stall  out  1  CPU stall
- p_req_valid  out  1  downstream request valid
- p_req_rw  out  1  downstream write enable
- p_req_addr  out  ADDR_W  downstream address
- p_wdata  out  DATA_W  downstream write data
- p_rdata  in  DATA_W  downstream read data; valid when p_ready is high
- p_ready  in  1  downstream completes the access in the cycle it is sampled high
- grant_data  out  1  1 while the DATA state owns the port

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE arbitration, evaluated each cycle:
  - If d_req_valid, and either !if_req_valid or starve_cnt < STARVE_MAX → DATA.
  - Else if if_req_valid → FETCH.
  - Else stay in IDLE.
- On grant, latch address, rw and wdata into request registers. rw is forced to 0 for FETCH.
- FETCH/DATA: hold p_req_valid=1 and all p_* outputs stable until p_ready=1.
  - In the p_ready cycle, capture p_rdata into if_rdata (FETCH) or into d_rdata (DATA read only).
  - Then go to RESP.
  - d_rdata is unchanged on a write completion.
- RESP: assert if_done or d_done for exactly one cycle, with p_req_valid=0, then go to IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each DATA grant made while if_req_valid=1.
  - Clears on every FETCH grant.
  - Unchanged otherwise.
- stall = (if_req_valid & !if_done) | (d_req_valid & !d_done). It is combinational.
- A requester dropping valid mid-transaction does not abort the transaction. The access completes and done still pulses.
- Simultaneous requests with starve_cnt == STARVE_MAX: fetch wins, and the counter clears.
- Changes to requester address/data after grant are ignored until the next grant.

## Timing
- Reset values: all outputs 0, if_rdata = d_rdata = 0, state = IDLE, starve_cnt = 0.
- RESET asserted mid-transaction: the next edge returns to IDLE, p_req_valid=0 and no done pulse.
- Latency, with a grant decided in IDLE at cycle t:
  - p_req_valid high from t+1.
  - p_ready first sampled high at t+k (k ≥ 1).
  - done pulses at t+k+1.
  - State is back in IDLE at t+k+2.
  - Minimum is 3 cycles per access (zero-wait memory).
- The p_* outputs and done pulses are registered (driven from FSM state and request registers), not from requester inputs.
- No back-to-back issue without passing through IDLE. One access is outstanding at a time.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE, FETCH, DATA, RESP)
  - STARVE_MAX default
  - width constants ADDR_W/DATA_W
- Sub-module arb_starve_cnt: the saturating counter with inc/clr/sat outputs.
- FSM, request registers and response buffers stay in mem_port_arbiter.

## Test plan
- Lone fetch, if_req_addr=0x8, p_ready on first valid cycle, p_rdata=0xE59F120C → p_req_addr=0x8 and rw=0 at t+1; if_done at t+2; if_rdata=0xE59F120C held afterwards; stall low after done.
- Simultaneous fetch 0x0 and read 0x200, starve_cnt=0 → DATA granted first (grant_data=1) and d_rdata=p_rdata; then FETCH; starve_cnt=1 then 0.
- Data requests held continuously with fetch pending, STARVE_MAX=4 → exactly 4 data grants, then a fetch grant; starve_cnt clears.
- Write to 0x800 with wdata=0x5, p_ready delayed 3 cycles → p_* stable for all 3 cycles, p_req_rw=1, d_done one pulse, d_rdata unchanged.
- RESET raised during a DATA wait → next cycle IDLE, all outputs 0, no d_done; a following fetch proceeds normally.
- d_req_valid dropped after grant → access completes and d_done still pulses once.
